axi_w_channel_slave: RTL and testbench

AXI3 write-channel slave that sits directly downstream of the core's AXI write master. It accepts an AW/W transaction, drives each data beat onto a single-cycle SRAM write port, and returns one B response per transaction. It works with the master's joint AW+W handshake, where address and first beat transfer in the same cycle. It also accepts INCR, FIXED and WRAP bursts of up to 16 beats.

---
 rtl/axi_w_channel_slave.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_axi_w_channel_slave.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_w_channel_slave.sv
// ---------------------------------------------------------------------------
// axi_w_channel_slave
//
// AXI3 write-channel slave that turns each accepted W beat into one cycle of
// a registered single-port SRAM write, and returns one B response per
// transaction. The address and the first data beat are always taken together
// in one cycle (the upstream master presents AW and W jointly). Bursts of up
// to 16 beats are supported in FIXED, INCR and WRAP modes.
//
// State table
//   state  | meaning
//   S_IDLE | waiting for AWVALID && WVALID together; beat 0 issued on accept
//   S_DATA | beats 1..AWLEN accepted, one per cycle while WVALID is high
//   S_RESP | BVALID high, BRESP/BID held until BREADY
//
// Ports
//   ACLK, ARESETn        clock, asynchronous active-low reset
//   AW*                  write address channel (AWREADY combinational)
//   W*                   write data channel (WREADY combinational)
//   B*                   write response channel (registered)
//   sram_wen/addr/wdata/wmask  registered SRAM write port, one cycle per beat
//   busy                 high while a transaction is in S_DATA or S_RESP
// ---------------------------------------------------------------------------

`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

module axi_w_channel_slave #(
    parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
    parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
    parameter int ID_WIDTH   = `AXI_ID_WIDTH,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,

    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [3:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic [ID_WIDTH-1:0]   AWID,
    input  logic                  AWVALID,
    output logic                  AWREADY,

    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [STRB_WIDTH-1:0] WSTRB,
    input  logic                  WLAST,
    input  logic [ID_WIDTH-1:0]   WID,
    input  logic                  WVALID,
    output logic                  WREADY,

    output logic [1:0]            BRESP,
    output logic [ID_WIDTH-1:0]   BID,
    output logic                  BVALID,
    input  logic                  BREADY,

    output logic                  sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    output logic [STRB_WIDTH-1:0] sram_wmask,

    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_DATA = 3'b010,
        S_RESP = 3'b100
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Next beat address. mode is the effective burst mode latched on accept,
    // so it is never the reserved encoding here. For WRAP the upper bits
    // (outside the window mask) stay put and only the low bits roll over.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] cur,
        input logic [2:0]            size,
        input logic [1:0]            mode,
        input logic [ADDR_WIDTH-1:0] mask
    );
        logic [ADDR_WIDTH-1:0] sum;
        sum = cur + (ADDR_WIDTH'(1) << size);
        case (mode)
            BURST_FIXED: next_addr = cur;
            BURST_WRAP:  next_addr = (cur & ~mask) | (sum & mask);
            default:     next_addr = sum;
        endcase
    endfunction

    state_t                state_q,      state_d;
    logic [ID_WIDTH-1:0]   id_q,         id_d;
    logic [3:0]            len_q,        len_d;
    logic [2:0]            size_q,       size_d;
    logic [1:0]            mode_q,       mode_d;
    logic [ADDR_WIDTH-1:0] wrap_mask_q,  wrap_mask_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [3:0]            cnt_q,        cnt_d;
    logic                  err_q,        err_d;
    logic                  bvalid_q,     bvalid_d;
    logic [1:0]            bresp_q,      bresp_d;
    logic [ID_WIDTH-1:0]   bid_q,        bid_d;
    logic                  sram_wen_q,   sram_wen_d;
    logic [ADDR_WIDTH-1:0] sram_addr_q,  sram_addr_d;
    logic [DATA_WIDTH-1:0] sram_wdata_q, sram_wdata_d;
    logic [STRB_WIDTH-1:0] sram_wmask_q, sram_wmask_d;

    logic                  aw_wrap_ok;
    logic [1:0]            aw_mode;
    logic [ADDR_WIDTH-1:0] aw_mask;
    logic                  aw_err;
    logic                  beat_last;
    logic                  beat_err;

    // Ready is combinational on the registered state; gating with ARESETn
    // keeps both low while reset is asserted even if the master is valid.
    assign AWREADY = ARESETn && (state_q == S_IDLE) && AWVALID && WVALID;
    assign WREADY  = ARESETn && (((state_q == S_IDLE) && AWVALID && WVALID)
                                 || (state_q == S_DATA));

    // Attributes of the transaction being offered in S_IDLE.
    always_comb begin
        aw_wrap_ok = (AWLEN == 4'd1) || (AWLEN == 4'd3)
                  || (AWLEN == 4'd7) || (AWLEN == 4'd15);
        aw_mask    = ((ADDR_WIDTH'(AWLEN) + ADDR_WIDTH'(1)) << AWSIZE)
                   - ADDR_WIDTH'(1);
        // An illegal WRAP length has no defined window, so it walks as INCR
        // while the error flag reports it. The reserved encoding also walks
        // as INCR.
        if ((AWBURST == BURST_WRAP) && aw_wrap_ok) begin
            aw_mode = BURST_WRAP;
        end else if (AWBURST == BURST_FIXED) begin
            aw_mode = BURST_FIXED;
        end else begin
            aw_mode = BURST_INCR;
        end
        aw_err = (AWBURST == BURST_RSVD)
              || ((AWBURST == BURST_WRAP) && !aw_wrap_ok)
              || (WID != AWID)
              || (WLAST != (AWLEN == 4'd0));
    end

    // Checks on beats 1..AWLEN. Length is owned by AWLEN; WLAST only feeds
    // the error flag.
    always_comb begin
        beat_last = (cnt_q == len_q);
        beat_err  = (WID != id_q) || (WLAST != beat_last);
    end

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        len_d        = len_q;
        size_d       = size_q;
        mode_d       = mode_q;
        wrap_mask_d  = wrap_mask_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        bid_d        = bid_q;
        sram_wen_d   = 1'b0;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        sram_wmask_d = sram_wmask_q;

        case (state_q)
            S_IDLE: begin
                if (AWVALID && WVALID) begin
                    id_d         = AWID;
                    len_d        = AWLEN;
                    size_d       = AWSIZE;
                    mode_d       = aw_mode;
                    wrap_mask_d  = aw_mask;
                    err_d        = aw_err;
                    cnt_d        = 4'd1;
                    sram_wen_d   = 1'b1;
                    sram_addr_d  = AWADDR;
                    sram_wdata_d = WDATA;
                    sram_wmask_d = WSTRB;
                    addr_d       = next_addr(AWADDR, AWSIZE, aw_mode, aw_mask);
                    if (AWLEN == 4'd0) begin
                        state_d  = S_RESP;
                        bvalid_d = 1'b1;
                        bid_d    = AWID;
                        bresp_d  = aw_err ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        state_d  = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (WVALID) begin
                    sram_wen_d   = 1'b1;
                    sram_addr_d  = addr_q;
                    sram_wdata_d = WDATA;
                    sram_wmask_d = WSTRB;
                    addr_d       = next_addr(addr_q, size_q, mode_q, wrap_mask_q);
                    cnt_d        = cnt_q + 4'd1;
                    err_d        = err_q || beat_err;
                    if (beat_last) begin
                        state_d  = S_RESP;
                        bvalid_d = 1'b1;
                        bid_d    = id_q;
                        bresp_d  = (err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end

            S_RESP: begin
                if (BREADY) begin
                    state_d  = S_IDLE;
                    bvalid_d = 1'b0;
                end
            end

            default: begin
                state_d  = S_IDLE;
                bvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= S_IDLE;
            id_q         <= '0;
            len_q        <= '0;
            size_q       <= '0;
            mode_q       <= BURST_INCR;
            wrap_mask_q  <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            bid_q        <= '0;
            sram_wen_q   <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_wmask_q <= '0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            len_q        <= len_d;
            size_q       <= size_d;
            mode_q       <= mode_d;
            wrap_mask_q  <= wrap_mask_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            bid_q        <= bid_d;
            sram_wen_q   <= sram_wen_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_wmask_q <= sram_wmask_d;
        end
    end

    assign BVALID     = bvalid_q;
    assign BRESP      = bresp_q;
    assign BID        = bid_q;
    assign sram_wen   = sram_wen_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_wmask = sram_wmask_q;
    assign busy       = (state_q == S_DATA) || (state_q == S_RESP);

endmodule

// File: tb/tb_axi_w_channel_slave.sv
// ---------------------------------------------------------------------------
// Bench for axi_w_channel_slave: a table of directed transactions, two
// hand-written multi-cycle sequences (AW stalled without W, reset
// mid-burst) and a randomized run, all checked against a transaction-level
// reference model of addresses, data and response.
// ---------------------------------------------------------------------------

module tb_axi_w_channel_slave;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int SW = 4;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic [AW-1:0] AWADDR;
    logic [3:0]    AWLEN;
    logic [2:0]    AWSIZE;
    logic [1:0]    AWBURST;
    logic [IW-1:0] AWID;
    logic          AWVALID;
    logic          AWREADY;
    logic [DW-1:0] WDATA;
    logic [SW-1:0] WSTRB;
    logic          WLAST;
    logic [IW-1:0] WID;
    logic          WVALID;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic [IW-1:0] BID;
    logic          BVALID;
    logic          BREADY;
    logic          sram_wen;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [SW-1:0] sram_wmask;
    logic          busy;

    always #5 ACLK = ~ACLK;

    axi_w_channel_slave #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .STRB_WIDTH(SW)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWID(AWID), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WID(WID),
        .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BID(BID), .BVALID(BVALID), .BREADY(BREADY),
        .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_wmask(sram_wmask), .busy(busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // SRAM write monitor
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } wr_t;
    wr_t wr_q[$];

    always @(negedge ACLK) begin
        if (sram_wen === 1'b1) wr_q.push_back({sram_addr, sram_wdata, sram_wmask});
    end

    // Transaction record: inputs plus table-level expectations.
    typedef struct {
        logic [31:0]      addr;
        int               len;
        int               size;
        logic [1:0]       burst;
        logic [3:0]       id;
        logic [31:0]      wdata0;
        logic [3:0]       strb0;
        int               bad_wid_beat;   // -1: none
        int               wlast_mode;     // 0 correct, 1 early on beat 0, 2 never
        int               gap_after;      // -1: none, else WVALID gap after this beat
        int               bready_dly;
        logic [1:0]       exp_bresp;
        int               n_exp;
        logic [0:3][31:0] exp_a;
    } vec_t;

    function automatic vec_t mk(
        input logic [31:0] addr, input int len, input int size, input logic [1:0] burst,
        input logic [3:0] id, input logic [31:0] wdata0, input logic [3:0] strb0,
        input int bad_wid_beat, input int wlast_mode, input int gap_after,
        input int bready_dly, input logic [1:0] exp_bresp, input int n_exp,
        input logic [0:3][31:0] exp_a);
        vec_t v;
        v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.id = id;
        v.wdata0 = wdata0; v.strb0 = strb0; v.bad_wid_beat = bad_wid_beat;
        v.wlast_mode = wlast_mode; v.gap_after = gap_after; v.bready_dly = bready_dly;
        v.exp_bresp = exp_bresp; v.n_exp = n_exp; v.exp_a = exp_a;
        return v;
    endfunction

    // ---------------- reference model ----------------
    function automatic bit m_wrap_ok(input int len);
        return (len == 1) || (len == 3) || (len == 7) || (len == 15);
    endfunction

    function automatic logic [31:0] m_addr(input logic [31:0] a, input int len,
                                           input int size, input logic [1:0] burst,
                                           input int i);
        longint unsigned nb, w, base, aa;
        nb = longint'(1) << size;
        aa = longint'(a);
        if (burst == 2'b00) return a;
        if (burst == 2'b10) begin
            w    = longint'(len + 1) * nb;
            base = (aa / w) * w;
            return 32'(base + ((aa - base) + longint'(i) * nb) % w);
        end
        return 32'(aa + longint'(i) * nb);
    endfunction

    function automatic logic [1:0] m_bresp(input vec_t v);
        bit err;
        err = (v.burst == 2'b11)
           || (v.burst == 2'b10 && !m_wrap_ok(v.len))
           || (v.bad_wid_beat >= 0 && v.bad_wid_beat <= v.len)
           || (v.wlast_mode != 0);
        return err ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [31:0] m_data(input vec_t v, input int i);
        return v.wdata0 + 32'(i) * 32'h0101_0101;
    endfunction

    function automatic logic [3:0] m_strb(input vec_t v, input int i);
        return v.strb0 ^ 4'(i);
    endfunction

    // ---------------- transaction driver + checker ----------------
    task automatic do_txn(input vec_t v, output logic [1:0] bresp_o);
        int  beat;
        int  guard;
        bit  gap_done;
        bit  stable;
        bit  chk_addr;
        logic [1:0]  r0;
        logic [3:0]  id0;
        beat     = 0;
        guard    = 0;
        gap_done = 0;
        chk_addr = !(v.burst == 2'b10 && !m_wrap_ok(v.len));
        wr_q.delete();
        @(negedge ACLK);
        while (beat <= v.len && guard < 100) begin
            if (v.gap_after >= 0 && beat == v.gap_after + 1 && !gap_done) begin
                AWVALID  = 1'b0;
                WVALID   = 1'b0;
                gap_done = 1;
                repeat (2) @(negedge ACLK);
            end
            AWVALID = (beat == 0);
            AWADDR  = v.addr;
            AWLEN   = 4'(v.len);
            AWSIZE  = 3'(v.size);
            AWBURST = v.burst;
            AWID    = v.id;
            WVALID  = 1'b1;
            WDATA   = m_data(v, beat);
            WSTRB   = m_strb(v, beat);
            WID     = (beat == v.bad_wid_beat) ? (v.id ^ 4'd1) : v.id;
            case (v.wlast_mode)
                0:       WLAST = (beat == v.len);
                1:       WLAST = (beat == 0) || (beat == v.len);
                default: WLAST = 1'b0;
            endcase
            #1;
            if (WREADY) beat++;
            @(negedge ACLK);
            guard++;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        WLAST   = 1'b0;
        #1;
        chk("beats_accepted", 64'(beat), 64'(v.len + 1));
        chk("bvalid_latency", 64'(BVALID), 64'd1);
        chk("busy_in_resp", 64'(busy), 64'd1);
        chk("bid", 64'(BID), 64'(v.id));
        chk("bresp_model", 64'(BRESP), 64'(m_bresp(v)));
        bresp_o = BRESP;
        r0      = BRESP;
        id0     = BID;
        stable  = 1;
        repeat (v.bready_dly) begin
            @(negedge ACLK);
            #1;
            if (BVALID !== 1'b1 || BRESP !== r0 || BID !== id0 || AWREADY !== 1'b0)
                stable = 0;
        end
        chk("b_held", 64'(stable), 64'd1);
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        #1;
        chk("bvalid_after_hs", 64'(BVALID), 64'd0);
        chk("busy_after_hs", 64'(busy), 64'd0);
        chk("write_count", 64'(wr_q.size()), 64'(v.len + 1));
        for (int i = 0; i < wr_q.size() && i <= v.len; i++) begin
            if (chk_addr)
                chk($sformatf("wr_addr[%0d]", i), 64'(wr_q[i].a),
                    64'(m_addr(v.addr, v.len, v.size, v.burst, i)));
            chk($sformatf("wr_data[%0d]", i), 64'(wr_q[i].d), 64'(m_data(v, i)));
            chk($sformatf("wr_mask[%0d]", i), 64'(wr_q[i].m), 64'(m_strb(v, i)));
        end
    endtask

    vec_t       tbl[12];
    vec_t       rv;
    logic [1:0] got_resp;
    bit         ok;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWID = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WID = '0; WVALID = 1'b0; BREADY = 1'b0;

        //                addr          len sz burst  id     wdata0         strb  wid wl gap brdy resp  n   expected addresses
        tbl[0]  = mk(32'h0000_1000,  0, 2, 2'b01, 4'h3, 32'hDEAD_BEEF, 4'hF, -1, 0, -1, 2, 2'b00, 1, {32'h1000, 32'h0, 32'h0, 32'h0});
        tbl[1]  = mk(32'h0000_2000,  3, 2, 2'b01, 4'h1, 32'h1111_1111, 4'hF, -1, 0,  1, 0, 2'b00, 4, {32'h2000, 32'h2004, 32'h2008, 32'h200C});
        tbl[2]  = mk(32'h0000_3008,  3, 2, 2'b10, 4'h2, 32'h2222_2222, 4'hF, -1, 0, -1, 1, 2'b00, 4, {32'h3008, 32'h300C, 32'h3000, 32'h3004});
        tbl[3]  = mk(32'h0000_4000,  2, 2, 2'b00, 4'h7, 32'h3333_3333, 4'h5, -1, 0, -1, 0, 2'b00, 3, {32'h4000, 32'h4000, 32'h4000, 32'h0});
        tbl[4]  = mk(32'h0000_4100,  1, 2, 2'b01, 4'h4, 32'h4444_4444, 4'hF,  1, 0, -1, 1, 2'b10, 2, {32'h4100, 32'h4104, 32'h0, 32'h0});
        tbl[5]  = mk(32'h0000_4200,  1, 2, 2'b01, 4'h9, 32'h5555_5555, 4'hF, -1, 1, -1, 0, 2'b10, 2, {32'h4200, 32'h4204, 32'h0, 32'h0});
        tbl[6]  = mk(32'h0000_4300,  2, 2, 2'b01, 4'hA, 32'h6666_6666, 4'hF, -1, 2, -1, 0, 2'b10, 3, {32'h4300, 32'h4304, 32'h4308, 32'h0});
        tbl[7]  = mk(32'h0000_5000,  1, 2, 2'b11, 4'hB, 32'h7777_7777, 4'hF, -1, 0, -1, 0, 2'b10, 2, {32'h5000, 32'h5004, 32'h0, 32'h0});
        tbl[8]  = mk(32'h0000_5100,  2, 2, 2'b10, 4'hC, 32'h8888_8888, 4'hF, -1, 0, -1, 0, 2'b10, 0, {32'h0, 32'h0, 32'h0, 32'h0});
        tbl[9]  = mk(32'hFFFF_FFFC,  1, 2, 2'b01, 4'hD, 32'h9999_9999, 4'hF, -1, 0, -1, 0, 2'b00, 2, {32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0});
        tbl[10] = mk(32'h0000_6005, 15, 0, 2'b10, 4'hE, 32'hAAAA_AAAA, 4'h1, -1, 0,  3, 1, 2'b00, 4, {32'h6005, 32'h6006, 32'h6007, 32'h6008});
        tbl[11] = mk(32'h0000_7012,  1, 1, 2'b10, 4'h0, 32'hBBBB_BBBB, 4'h3, -1, 0, -1, 3, 2'b00, 2, {32'h7012, 32'h7010, 32'h0, 32'h0});

        // Reset state, with the master already offering AW+W.
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        repeat (3) @(negedge ACLK);
        #1;
        chk("rst_ctrl", 64'({BVALID, BRESP, BID, sram_wen, busy, AWREADY, WREADY}), 64'd0);
        chk("rst_sram_addr", 64'(sram_addr), 64'd0);
        chk("rst_sram_data", 64'({sram_wdata, sram_wmask}), 64'd0);
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;

        // Directed table.
        for (int t = 0; t < 12; t++) begin
            do_txn(tbl[t], got_resp);
            chk($sformatf("tbl%0d_bresp", t), 64'(got_resp), 64'(tbl[t].exp_bresp));
            for (int i = 0; i < tbl[t].n_exp; i++) begin
                if (i < wr_q.size())
                    chk($sformatf("tbl%0d_addr[%0d]", t, i), 64'(wr_q[i].a), 64'(tbl[t].exp_a[i]));
            end
        end

        // AW offered without W: must stall until W joins it.
        wr_q.delete();
        @(negedge ACLK);
        AWVALID = 1'b1; WVALID = 1'b0;
        AWADDR = 32'h8000; AWLEN = 4'd0; AWSIZE = 3'd2; AWBURST = 2'b01; AWID = 4'h6;
        WID = 4'h6; WDATA = 32'hCAFE_F00D; WSTRB = 4'h3; WLAST = 1'b1;
        ok = 1;
        repeat (5) begin
            #1;
            if (AWREADY !== 1'b0 || WREADY !== 1'b0) ok = 0;
            @(negedge ACLK);
        end
        chk("aw_only_stall", 64'(ok), 64'd1);
        WVALID = 1'b1;
        #1;
        chk("aw_w_joint_accept", 64'({AWREADY, WREADY}), 64'b11);
        @(negedge ACLK);
        #1;
        chk("aw_only_bvalid", 64'(BVALID), 64'd1);
        chk("no_accept_in_resp", 64'({AWREADY, WREADY}), 64'b00);
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        BREADY  = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        #1;
        chk("aw_only_bvalid_low", 64'(BVALID), 64'd0);
        chk("aw_only_writes", 64'(wr_q.size()), 64'd1);
        if (wr_q.size() > 0)
            chk("aw_only_write", 64'({wr_q[0].a, wr_q[0].m}), 64'({32'h8000, 4'h3}));

        // Reset mid-burst after beat 1 of a 4-beat INCR.
        wr_q.delete();
        @(negedge ACLK);
        AWVALID = 1'b1; WVALID = 1'b1;
        AWADDR = 32'h9000; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWID = 4'h2;
        WID = 4'h2; WDATA = 32'h0; WSTRB = 4'hF; WLAST = 1'b0;
        #1;
        chk("rst_burst_accept", 64'(AWREADY), 64'd1);
        @(negedge ACLK);
        AWVALID = 1'b0;
        WDATA   = 32'h1;
        @(negedge ACLK);
        WVALID = 1'b0;
        #2;
        ARESETn = 1'b0;
        #1;
        chk("midrst_ctrl", 64'({BVALID, BRESP, BID, sram_wen, busy, AWREADY, WREADY}), 64'd0);
        chk("midrst_sram", 64'({sram_addr, sram_wmask}), 64'd0);
        chk("midrst_prior_writes", 64'(wr_q.size()), 64'd2);
        @(negedge ACLK);
        ARESETn = 1'b1;
        WVALID  = 1'b1;
        WDATA   = 32'h2;
        wr_q.delete();
        ok = 1;
        repeat (4) begin
            #1;
            if (BVALID !== 1'b0 || busy !== 1'b0) ok = 0;
            @(negedge ACLK);
        end
        WVALID = 1'b0;
        chk("midrst_no_b", 64'(ok), 64'd1);
        chk("midrst_no_writes", 64'(wr_q.size()), 64'd0);
        rv = mk(32'h0000_A000, 0, 2, 2'b01, 4'h5, 32'h1234_5678, 4'hF, -1, 0, -1, 0, 2'b00, 1, {32'hA000, 32'h0, 32'h0, 32'h0});
        do_txn(rv, got_resp);
        chk("after_rst_okay", 64'(got_resp), 64'd0);

        // Randomized transactions against the model.
        for (int t = 0; t < 40; t++) begin
            rv.burst  = 2'($urandom_range(0, 3));
            rv.size   = int'($urandom_range(0, 2));
            if (rv.burst == 2'b10) begin
                case ($urandom_range(0, 3))
                    0:       rv.len = 1;
                    1:       rv.len = 3;
                    2:       rv.len = 7;
                    default: rv.len = 15;
                endcase
            end else begin
                rv.len = int'($urandom_range(0, 15));
            end
            rv.addr   = $urandom & ~((32'd1 << rv.size) - 32'd1);
            rv.id     = 4'($urandom);
            rv.wdata0 = $urandom;
            rv.strb0  = 4'($urandom);
            rv.bad_wid_beat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, rv.len)) : -1;
            if ($urandom_range(0, 5) == 0)
                rv.wlast_mode = (rv.len > 0) ? int'($urandom_range(1, 2)) : 2;
            else
                rv.wlast_mode = 0;
            rv.gap_after  = ($urandom_range(0, 2) == 0 && rv.len > 0) ? int'($urandom_range(0, rv.len - 1)) : -1;
            rv.bready_dly = int'($urandom_range(0, 3));
            rv.exp_bresp  = 2'b00;
            rv.n_exp      = 0;
            rv.exp_a      = '0;
            do_txn(rv, got_resp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
